// File: rtl/subtractor_if.sv
// Valid/ready stream bundle for the subtractor: operand side (in_*, a, b) and result side (out_*, d, borrow).
interface subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, borrow
  );
endinterface

// File: rtl/subtractor.sv
// Pipelined unsigned subtractor d = a - b with borrow, LATENCY stages and a global-stall valid/ready pipeline.
// Build macro SUBTRACTOR_SATURATE_EN: clamp d to 0 whenever borrow is set.
module subtractor #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic        srst,
  subtractor_if.slave bus
);
  logic [WIDTH:0]   diff_full;
  logic [WIDTH-1:0] diff_res;
  logic             diff_borrow;

  always_comb begin
    diff_full   = {1'b0, bus.a} - {1'b0, bus.b};
    diff_borrow = diff_full[WIDTH];
`ifdef SUBTRACTOR_SATURATE_EN
    diff_res    = diff_borrow ? '0 : diff_full[WIDTH-1:0];
`else
    diff_res    = diff_full[WIDTH-1:0];
`endif
  end

  generate
    if (LATENCY == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, aclk, arstn, srst};

      assign bus.out_valid = bus.in_valid;
      assign bus.in_ready  = bus.out_ready;
      assign bus.d         = diff_res;
      assign bus.borrow    = diff_borrow;
    end else begin : g_pipe
      logic [LATENCY-1:0] valid_q;
      logic [LATENCY-1:0] valid_d;
      logic [LATENCY-1:0] borrow_q;
      logic [LATENCY-1:0] borrow_d;
      logic [WIDTH-1:0]   d_q [LATENCY];
      logic [WIDTH-1:0]   d_d [LATENCY];
      logic               en;

      // Whole pipeline advances together; a stalled output freezes every stage.
      assign en = bus.out_ready | ~valid_q[LATENCY-1];

      always_comb begin
        valid_d  = valid_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        if (srst) begin
          valid_d  = '0;
          borrow_d = '0;
          for (int i = 0; i < LATENCY; i++) begin
            d_d[i] = '0;
          end
        end else if (en) begin
          valid_d[0]  = bus.in_valid;
          borrow_d[0] = diff_borrow;
          d_d[0]      = diff_res;
          for (int i = 1; i < LATENCY; i++) begin
            valid_d[i]  = valid_q[i-1];
            borrow_d[i] = borrow_q[i-1];
            d_d[i]      = d_q[i-1];
          end
        end
      end

      always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
          valid_q  <= '0;
          borrow_q <= '0;
          for (int i = 0; i < LATENCY; i++) begin
            d_q[i] <= '0;
          end
        end else begin
          valid_q  <= valid_d;
          borrow_q <= borrow_d;
          d_q      <= d_d;
        end
      end

      assign bus.in_ready  = en;
      assign bus.out_valid = valid_q[LATENCY-1];
      assign bus.d         = d_q[LATENCY-1];
      assign bus.borrow    = borrow_q[LATENCY-1];
    end
  endgenerate
endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench for subtractor: LATENCY 1, 3 and 0 instances against a plain-arithmetic model.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
module tb_subtractor;
  localparam int W = 32;
  localparam logic [W-1:0] MAXV = '1;
`ifdef SUBTRACTOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic aclk  = 1'b0;
  logic arstn = 1'b0;
  logic srst  = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 aclk = ~aclk;

  subtractor_if #(.WIDTH(W)) if1 ();
  subtractor_if #(.WIDTH(W)) if3 ();
  subtractor_if #(.WIDTH(W)) if0 ();

  subtractor #(.LATENCY(1), .WIDTH(W)) u_l1 (.aclk(aclk), .arstn(arstn), .srst(srst), .bus(if1));
  subtractor #(.LATENCY(3), .WIDTH(W)) u_l3 (.aclk(aclk), .arstn(arstn), .srst(srst), .bus(if3));
  subtractor #(.LATENCY(0), .WIDTH(W)) u_l0 (.aclk(aclk), .arstn(arstn), .srst(srst), .bus(if0));

  // Reference: {borrow, d} from ordinary integer comparison and subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    if (ua >= ub) return {1'b0, W'(ua - ub)};
    if (SAT) return {1'b1, {W{1'b0}}};
    return {1'b1, W'(ua + (64'd1 << W) - ub)};
  endfunction

  task automatic idle_all();
    if1.in_valid = 1'b0; if1.out_ready = 1'b1; if1.a = '0; if1.b = '0;
    if3.in_valid = 1'b0; if3.out_ready = 1'b1; if3.a = '0; if3.b = '0;
    if0.in_valid = 1'b0; if0.out_ready = 1'b1; if0.a = '0; if0.b = '0;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    srst  = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      if1.a = $urandom; if1.b = $urandom; if1.in_valid = 1'($urandom_range(0, 1));
      if3.a = $urandom; if3.b = $urandom; if3.in_valid = 1'($urandom_range(0, 1));
    end
    #1;
    total_cnt++;
    if (if3.out_valid !== 1'b0) $display("FAIL reset_hold_l3_valid got=%0b want=0", if3.out_valid);
    else pass_cnt++;
    @(negedge aclk);
    idle_all();
    arstn = 1'b1;
    #1;
    total_cnt++;
    if ({if1.out_valid, if1.borrow, if1.d, if1.in_ready} !== {1'b0, 1'b0, {W{1'b0}}, 1'b1})
      $display("FAIL reset_l1 got v=%0b br=%0b d=%h rdy=%0b want v=0 br=0 d=0 rdy=1",
               if1.out_valid, if1.borrow, if1.d, if1.in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({if3.out_valid, if3.borrow, if3.d, if3.in_ready} !== {1'b0, 1'b0, {W{1'b0}}, 1'b1})
      $display("FAIL reset_l3 got v=%0b br=%0b d=%h rdy=%0b want v=0 br=0 d=0 rdy=1",
               if3.out_valid, if3.borrow, if3.d, if3.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    @(negedge aclk);
    if1.a = 32'd100; if1.b = 32'd58; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
    @(negedge aclk);
    #1;
    total_cnt++;
    if ({if1.out_valid, if1.borrow, if1.d} !== {1'b1, 1'b0, 32'd42})
      $display("FAIL basic_result got v=%0b br=%0b d=%0d want v=1 br=0 d=42",
               if1.out_valid, if1.borrow, if1.d);
    else pass_cnt++;
    if1.in_valid = 1'b0;
    @(negedge aclk);
    #1;
    total_cnt++;
    if (if1.out_valid !== 1'b0) $display("FAIL basic_gap got v=%0b want v=0", if1.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [7];
    logic [W-1:0] tb [7];
    logic [W:0]   exp;
    ta = '{32'd0, 32'd5, 32'd0,  32'd123456, MAXV, MAXV, 32'd7};
    tb = '{32'd1, 32'd5, MAXV,   32'd0,      MAXV, 32'd0, 32'd9};
    for (int k = 0; k < 7; k++) begin
      @(negedge aclk);
      if1.a = ta[k]; if1.b = tb[k]; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
      @(negedge aclk);
      if1.in_valid = 1'b0;
      #1;
      exp = ref_sub(ta[k], tb[k]);
      total_cnt++;
      if ({if1.out_valid, if1.borrow, if1.d} !== {1'b1, exp})
        $display("FAIL boundary_%0d a=%h b=%h got v=%0b br=%0b d=%h want v=1 br=%0b d=%h",
                 k, ta[k], tb[k], if1.out_valid, if1.borrow, if1.d, exp[W], exp[W-1:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_latency0();
    logic [W:0] exp;
    logic       iv;
    logic       ordy;
    @(negedge aclk);
    if0.a = 32'd7; if0.b = 32'd9; if0.in_valid = 1'b1; if0.out_ready = 1'b0;
    #1;
    exp = ref_sub(32'd7, 32'd9);
    total_cnt++;
    if ({if0.out_valid, if0.in_ready, if0.borrow, if0.d} !== {1'b1, 1'b0, exp})
      $display("FAIL lat0_fixed got v=%0b rdy=%0b br=%0b d=%h want v=1 rdy=0 br=%0b d=%h",
               if0.out_valid, if0.in_ready, if0.borrow, if0.d, exp[W], exp[W-1:0]);
    else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      if0.a = $urandom;
      if0.b = (k % 4 == 0) ? if0.a : 32'($urandom);
      if0.in_valid = iv; if0.out_ready = ordy;
      #1;
      exp = ref_sub(if0.a, if0.b);
      total_cnt++;
      if ({if0.out_valid, if0.in_ready, if0.borrow, if0.d} !== {iv, ordy, exp})
        $display("FAIL lat0_rand_%0d got v=%0b rdy=%0b br=%0b d=%h want v=%0b rdy=%0b br=%0b d=%h",
                 k, if0.out_valid, if0.in_ready, if0.borrow, if0.d, iv, ordy, exp[W], exp[W-1:0]);
      else pass_cnt++;
    end
    if0.in_valid = 1'b0; if0.out_ready = 1'b1;
  endtask

  task automatic test_back_pressure();
    int sent = 0;
    int got = 0;
    int first_out = -1;
    int extra = 0;
    logic [W-1:0] held = '0;
    for (int k = 0; k < 60 && got < 8; k++) begin
      @(negedge aclk);
      if3.out_ready = !(k >= 4 && k <= 8);
      if (sent < 8) begin
        if3.in_valid = 1'b1; if3.a = W'(sent + 10); if3.b = W'(sent);
      end else begin
        if3.in_valid = 1'b0;
      end
      #1;
      if (k >= 4 && k <= 8) begin
        total_cnt++;
        if (if3.in_ready !== 1'b0) $display("FAIL bp_stall_ready_%0d got=%0b want=0", k, if3.in_ready);
        else pass_cnt++;
        if (k == 4) held = if3.d;
        else begin
          total_cnt++;
          if (if3.d !== held) $display("FAIL bp_stall_hold_%0d got d=%h want d=%h", k, if3.d, held);
          else pass_cnt++;
        end
      end
      if (if3.out_valid && if3.out_ready) begin
        if (first_out < 0) first_out = k;
        total_cnt++;
        if ({if3.borrow, if3.d} !== {1'b0, 32'd10})
          $display("FAIL bp_result_%0d got br=%0b d=%0d want br=0 d=10", got, if3.borrow, if3.d);
        else pass_cnt++;
        got++;
      end
      if (if3.in_valid && if3.in_ready) sent++;
    end
    total_cnt++;
    if (first_out != 3) $display("FAIL bp_latency got first_out_cycle=%0d want 3", first_out);
    else pass_cnt++;
    total_cnt++;
    if (got != 8 || sent != 8) $display("FAIL bp_count got results=%0d sent=%0d want 8/8", got, sent);
    else pass_cnt++;
    repeat (5) begin
      @(negedge aclk);
      if3.in_valid = 1'b0; if3.out_ready = 1'b1;
      #1;
      if (if3.out_valid) extra++;
    end
    total_cnt++;
    if (extra != 0) $display("FAIL bp_duplicates got extra=%0d want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W:0]   exp_q [$];
    logic [W:0]   exp;
    logic         prev_stall = 1'b0;
    logic [W:0]   prev_out = '0;
    int           bad_ready = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge aclk);
      if3.out_ready = ($urandom_range(0, 3) != 0);
      if3.in_valid  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin if3.a = $urandom; if3.b = $urandom; end
        1: begin if3.a = $urandom; if3.b = if3.a; end
        2: begin if3.a = '0; if3.b = MAXV; end
        default: begin if3.a = $urandom; if3.b = '0; end
      endcase
      #1;
      if (if3.in_ready !== (if3.out_ready | ~if3.out_valid)) bad_ready++;
      if (prev_stall) begin
        total_cnt++;
        if ({if3.out_valid, if3.borrow, if3.d} !== {1'b1, prev_out})
          $display("FAIL rand_hold_%0d got v=%0b br=%0b d=%h want v=1 br=%0b d=%h",
                   k, if3.out_valid, if3.borrow, if3.d, prev_out[W], prev_out[W-1:0]);
        else pass_cnt++;
      end
      if (if3.out_valid && if3.out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : {1'bx, {W{1'bx}}};
        total_cnt++;
        if ({if3.borrow, if3.d} !== exp)
          $display("FAIL rand_out_%0d got br=%0b d=%h want br=%0b d=%h",
                   k, if3.borrow, if3.d, exp[W], exp[W-1:0]);
        else pass_cnt++;
      end
      if (if3.in_valid && if3.in_ready) exp_q.push_back(ref_sub(if3.a, if3.b));
      prev_stall = if3.out_valid && !if3.out_ready;
      prev_out   = {if3.borrow, if3.d};
    end
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      @(negedge aclk);
      if3.in_valid = 1'b0; if3.out_ready = 1'b1;
      #1;
      if (if3.out_valid) begin
        exp = exp_q.pop_front();
        total_cnt++;
        if ({if3.borrow, if3.d} !== exp)
          $display("FAIL rand_drain_%0d got br=%0b d=%h want br=%0b d=%h",
                   k, if3.borrow, if3.d, exp[W], exp[W-1:0]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rand_lost got pending=%0d want 0", exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (bad_ready != 0) $display("FAIL rand_in_ready got bad_cycles=%0d want 0", bad_ready);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    @(negedge aclk);
    if3.a = 32'd50; if3.b = 32'd20; if3.in_valid = 1'b1; if3.out_ready = 1'b1;
    @(negedge aclk);
    if3.a = 32'd60;
    @(negedge aclk);
    if3.in_valid = 1'b0;
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
    #1;
    total_cnt++;
    if ({if3.out_valid, if3.borrow, if3.d, if3.in_ready} !== {1'b0, 1'b0, {W{1'b0}}, 1'b1})
      $display("FAIL srst_clear got v=%0b br=%0b d=%h rdy=%0b want v=0 br=0 d=0 rdy=1",
               if3.out_valid, if3.borrow, if3.d, if3.in_ready);
    else pass_cnt++;
    repeat (6) begin
      @(negedge aclk);
      #1;
      if (if3.out_valid) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL srst_flushed got ghost_results=%0d want 0", seen);
    else pass_cnt++;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_basic();
    test_boundaries();
    test_latency0();
    test_back_pressure();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
